// File: rtl/serial_add_sched_if.sv
// Requester and response channels of the serial add scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial add cell (half-adder pair plus
// carry register) between two requesters; result returned on a valid/ready channel.
module serial_add_sched #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_sched_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic gnt0, gnt1;
  logic bit_a, bit_b, s_bit, c_next;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    rsp_valid_d = rsp_valid_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    bit_a  = a_q[cnt_q];
    bit_b  = b_q[cnt_q];
    s_bit  = bit_a ^ bit_b ^ carry_q;
    c_next = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));

    unique case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_id_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_id_q);
        if (gnt0 || gnt1) begin
          a_d       = gnt1 ? bus.req1_a : bus.req0_a;
          b_d       = gnt1 ? bus.req1_b : bus.req0_b;
          id_d      = gnt1;
          last_id_d = gnt1;
          carry_d   = 1'b0;
          cnt_d     = '0;
          state_d   = ADD;
        end
      end
      ADD: begin
        acc_d[cnt_q] = s_bit;
        carry_d      = c_next;
        cnt_d        = cnt_q + CNT_W'(1);
        // Working register keeps rsp_sum stable until the new result is complete.
        if (cnt_q == LAST_BIT) begin
          sum_d       = acc_d;
          cout_d      = c_next;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_id     = id_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched: directed cases, mid-op reset and
// randomized traffic against a plain-arithmetic reference model.
module tb_serial_add_sched;
  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
    int               acc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;

  serial_add_sched_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sched #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   idle = 1;
  int   last_id = 1;
  bit   no_new = 0;
  bit   last_hs0, last_hs1;
  bit   held_v = 0;
  int   n_hs = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom % 8)
      0: return '1;
      1: return '0;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  task automatic expect_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   s;
    s      = int'(a) + int'(b);
    e.sum  = WIDTH'(s % (1 << WIDTH));
    e.cout = (s >= (1 << WIDTH));
    e.id   = id;
    e.acc  = cyc + 1;
    sb.push_back(e);
    last_id = int'(id);
    idle    = 0;
    n_hs++;
  endtask

  task automatic drive_one(input bit hs, input bit rnd, input bit keep, input logic v_in,
                           input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                           output logic v_out, output logic [WIDTH-1:0] a_out,
                           output logic [WIDTH-1:0] b_out);
    v_out = v_in;
    a_out = a_in;
    b_out = b_in;
    if (hs && !keep) begin
      // Operands scrambled right after the accept: the operation must not see them.
      a_out = rnd_op();
      b_out = rnd_op();
      v_out = rnd && !no_new && ($urandom_range(0, 1) == 1);
    end else if (rnd && !v_in && !no_new && $urandom_range(0, 2) == 0) begin
      v_out = 1'b1;
      a_out = rnd_op();
      b_out = rnd_op();
    end
  endtask

  task automatic step(input bit rnd, input bit keep);
    logic r0e, r1e;
    bit   hs0, hs1, rhs;
    logic v;
    logic [WIDTH-1:0] a, b;
    @(negedge clk);
    r0e = 1'b0;
    r1e = 1'b0;
    if (idle) begin
      if (bus.req0_valid && bus.req1_valid) begin
        r0e = (last_id == 1);
        r1e = (last_id == 0);
      end else begin
        r0e = bus.req0_valid;
        r1e = bus.req1_valid;
      end
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(r0e));
    chk("req1_ready", 32'(bus.req1_ready), 32'(r1e));
    chk("busy", 32'(busy), 32'(!idle));
    hs0 = bus.req0_valid && r0e;
    hs1 = bus.req1_valid && r1e;
    rhs = bus.rsp_valid && bus.rsp_ready;
    if (hs0) expect_op(1'b0, bus.req0_a, bus.req0_b);
    if (hs1) expect_op(1'b1, bus.req1_a, bus.req1_b);
    @(posedge clk);
    #1;
    if (rhs) idle = 1;
    last_hs0 = hs0;
    last_hs1 = hs1;
    drive_one(hs0, rnd, keep, bus.req0_valid, bus.req0_a, bus.req0_b, v, a, b);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    drive_one(hs1, rnd, keep, bus.req1_valid, bus.req1_a, bus.req1_b, v, a, b);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    if (rnd) bus.rsp_ready = ($urandom % 4) != 0;
  endtask

  task automatic settle(input int bound, input string name);
    int n = 0;
    while (!(idle && sb.size() == 0 && !bus.req0_valid && !bus.req1_valid) && n < bound) begin
      step(0, 0);
      n++;
    end
    chk(name, 32'(sb.size() + int'(!idle) + int'(bus.req0_valid) + int'(bus.req1_valid)), 0);
  endtask

  task automatic check_reset_outputs(input string tag, input logic r0e);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_sum"}, 32'(bus.rsp_sum), 0);
    chk({tag, "_rsp_cout"}, 32'(bus.rsp_cout), 0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'(r0e));
    chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 0);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] h_sum;
    logic             h_cout, h_id;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (held_v) begin
          chk("stall_sum", 32'(bus.rsp_sum), 32'(h_sum));
          chk("stall_cout", 32'(bus.rsp_cout), 32'(h_cout));
          chk("stall_id", 32'(bus.rsp_id), 32'(h_id));
        end else begin
          chk("rsp_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb[0];
            chk("latency", 32'(cyc - e.acc), WIDTH);
            chk("rsp_sum", 32'(bus.rsp_sum), 32'(e.sum));
            chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
            chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          end
        end
        h_sum  = bus.rsp_sum;
        h_cout = bus.rsp_cout;
        h_id   = bus.rsp_id;
        if (bus.rsp_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          held_v = 0;
        end else begin
          held_v = 1;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
    #12;
    check_reset_outputs("por", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add and carry-chain cases.
    bus.req0_valid = 1'b1; bus.req0_a = 8'h5A; bus.req0_b = 8'h3C;
    settle(40, "basic_done");
    chk("basic_sum_out", 32'(bus.rsp_sum), 32'h96);
    bus.req1_valid = 1'b1; bus.req1_a = 8'hFF; bus.req1_b = 8'h01;
    settle(40, "carry1_done");
    chk("carry1_sum_out", 32'(bus.rsp_sum), 32'h00);
    chk("carry1_cout_out", 32'(bus.rsp_cout), 1);
    bus.req0_valid = 1'b1; bus.req0_a = 8'hFF; bus.req0_b = 8'hFF;
    settle(40, "carry2_done");
    chk("carry2_sum_out", 32'(bus.rsp_sum), 32'hFE);

    // Back-pressure with a second requester waiting.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h33; bus.req0_b = 8'h44;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h01; bus.req1_b = 8'h02;
    n = 0;
    while (!bus.rsp_valid && n < 30) begin step(0, 0); n++; end
    chk("bp_rsp_seen", 32'(bus.rsp_valid), 1);
    repeat (5) step(0, 0);
    bus.rsp_ready = 1'b1;
    settle(60, "bp_done");

    // Reset during the 4th ADD cycle.
    bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
    n = 0;
    last_hs0 = 0;
    while (!last_hs0 && n < 20) begin step(0, 0); n++; end
    chk("rst_accept_seen", 32'(last_hs0), 1);
    repeat (3) step(0, 0);
    #2;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h10; bus.req0_b = 8'h01;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h20; bus.req1_b = 8'h02;
    #1;
    check_reset_outputs("midop", 1'b1);
    sb.delete();
    held_v  = 0;
    idle    = 1;
    last_id = 1;
    rst_n   = 1'b1;

    // Tie arbitration with both requesters continuously valid.
    n_hs = 0;
    n = 0;
    while (n_hs < 4 && n < 100) begin step(0, 1); n++; end
    chk("tie_accepts", 32'(n_hs), 4);
    settle(100, "tie_done");

    // Randomized traffic, then drain.
    repeat (2500) step(1, 0);
    no_new = 1;
    n = 0;
    while (!(idle && sb.size() == 0 && !bus.req0_valid && !bus.req1_valid) && n < 400) begin
      step(1, 0);
      n++;
    end
    bus.rsp_ready = 1'b1;
    settle(100, "drain_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
